// File: rtl/universal_register_counter.sv
// Universal WIDTH-bit register: load, shift, rotate and modulo up/down count.
// Ports: clk, rst(async low), clr, en, mode[2:0], d, sin_r, sin_l -> q, sout, tc.
module universal_register_counter #(
  parameter int                 WIDTH     = 4,
  parameter int                 MODULUS   = 2**WIDTH,
  parameter logic [WIDTH-1:0]   RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             tc
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ASR  = 3'b100,
    M_ROL  = 3'b101,
    M_UP   = 3'b110,
    M_DOWN = 3'b111
  } mode_e;

  // MODULUS may equal 2**WIDTH, so compare in WIDTH+1 bits.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   TOP_W = MOD_W - 1'b1;
  localparam logic [WIDTH-1:0] TOP   = TOP_W[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_s_nxt;
  logic [WIDTH:0]   w_qx;
  mode_e            w_mode;

  assign w_mode = mode_e'(mode);
  assign w_qx   = {1'b0, r_q};

  always_comb begin
    w_q_nxt = r_q;
    w_s_nxt = r_sout;
    unique case (w_mode)
      M_HOLD: ;
      M_LOAD: w_q_nxt = d;
      M_SHL: begin
        w_q_nxt = {r_q[WIDTH-2:0], sin_r};
        w_s_nxt = r_q[WIDTH-1];
      end
      M_SHR: begin
        w_q_nxt = {sin_l, r_q[WIDTH-1:1]};
        w_s_nxt = r_q[0];
      end
      M_ASR: begin
        w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_s_nxt = r_q[0];
      end
      M_ROL: begin
        w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_s_nxt = r_q[WIDTH-1];
      end
      // Out-of-range values (after a load) wrap to 0 / MODULUS-1.
      M_UP: begin
        if (w_qx >= TOP_W) w_q_nxt = '0;
        else               w_q_nxt = r_q + 1'b1;
      end
      M_DOWN: begin
        if (r_q == '0)          w_q_nxt = TOP;
        else if (w_qx >= MOD_W) w_q_nxt = TOP;
        else                    w_q_nxt = r_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= RST_VALUE;
      r_sout <= 1'b0;
    end else if (clr) begin
      r_q    <= RST_VALUE;
      r_sout <= 1'b0;
    end else if (en) begin
      r_q    <= w_q_nxt;
      r_sout <= w_s_nxt;
    end
  end

  assign q    = r_q;
  assign sout = r_sout;
  assign tc   = rst & en & ~clr &
                (((w_mode == M_UP)   & (r_q == TOP)) |
                 ((w_mode == M_DOWN) & (r_q == '0)));

endmodule
